// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multiply/divide execution unit for the E stage. Owns the HI/LO register
//   pair, runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations
//   behind a busy handshake, services MTHI/MTLO writes and MFHI/MFLO reads.
//
//   Ports
//     clk      in   1   clock, rising edge
//     reset    in   1   synchronous, active-high
//     A        in   32  rs operand (forwarded)
//     B        in   32  rt operand (forwarded)
//     start    in   1   launch op selected by MUL_SEL (one-cycle pulse)
//     MUL_SEL  in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     w        in   1   MTHI/MTLO write request
//     W_SEL    in   1   1 = write HI, 0 = write LO
//     HL_SEL   in   1   1 = read HI, 0 = read LO
//     flush    in   1   abort in-flight op (only when MD_FLUSH_EN is defined)
//     busy     out  1   op in flight (registered)
//     HL_out   out  32  combinational read of HI or LO
//
//   Optional feature macro: MD_FLUSH_EN
//     Defined   : flush port exists; flush forces IDLE, keeps HI/LO, and
//                 suppresses start and w in the same cycle.
//     Undefined : no flush port; a started op always commits.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    input  logic [1:0]  MUL_SEL,
    input  logic        w,
    input  logic        W_SEL,
    input  logic        HL_SEL,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] HL_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [1:0]       op_q;

    // Result that will be committed to HI/LO at the final busy edge.
    logic [31:0]      res_hi_d;
    logic [31:0]      res_lo_d;
    logic             flush_act;

`ifdef MD_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Signed 32/32 divide: quotient truncated toward zero, remainder takes the
    // dividend's sign. Works on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of overflowing. Returns {rem, quo}.
    function automatic logic [63:0] sdiv32(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] n_mag;
        logic [31:0] d_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] quo;
        logic [31:0] rem;
        n_mag = n[31] ? (32'd0 - n) : n;
        d_mag = d[31] ? (32'd0 - d) : d;
        q_mag = n_mag / d_mag;
        r_mag = n_mag % d_mag;
        quo   = (n[31] ^ d[31]) ? (32'd0 - q_mag) : q_mag;
        rem   = n[31] ? (32'd0 - r_mag) : r_mag;
        return {rem, quo};
    endfunction

    // Unsigned 32/32 divide. Returns {rem, quo}.
    function automatic logic [63:0] udiv32(input logic [31:0] n, input logic [31:0] d);
        return {n % d, n / d};
    endfunction

    // Signed 32x32 -> 64 product via sign-extended operands.
    function automatic logic [63:0] smul32(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] x_ext;
        logic [63:0] y_ext;
        x_ext = {{32{x[31]}}, x};
        y_ext = {{32{y[31]}}, y};
        return x_ext * y_ext;
    endfunction

    // Unsigned 32x32 -> 64 product.
    function automatic logic [63:0] umul32(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] x_ext;
        logic [63:0] y_ext;
        x_ext = {32'd0, x};
        y_ext = {32'd0, y};
        return x_ext * y_ext;
    endfunction

    // Result selection from the latched operands; a zero divisor keeps HI/LO.
    always_comb begin
        res_hi_d = hi_q;
        res_lo_d = lo_q;
        case (op_q)
            OP_MULT: begin
                {res_hi_d, res_lo_d} = smul32(a_q, b_q);
            end
            OP_MULTU: begin
                {res_hi_d, res_lo_d} = umul32(a_q, b_q);
            end
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    {res_hi_d, res_lo_d} = sdiv32(a_q, b_q);
                end else begin
                    res_hi_d = hi_q;
                    res_lo_d = lo_q;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    {res_hi_d, res_lo_d} = udiv32(a_q, b_q);
                end else begin
                    res_hi_d = hi_q;
                    res_lo_d = lo_q;
                end
            end
            default: begin
                res_hi_d = hi_q;
                res_lo_d = lo_q;
            end
        endcase
    end

    // Control FSM, countdown, operand latch and HI/LO register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'b00;
        end else if (flush_act) begin
            // Abort wins over commit, start and w in the same cycle.
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= MUL_SEL;
                        cnt_q   <= MUL_SEL[1] ? DIV_LOAD : MULT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (w) begin
                        if (W_SEL) begin
                            hi_q <= A;
                        end else begin
                            lo_q <= A;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start and w are ignored while an op is in flight.
                    if (cnt_q == CNT_ONE) begin
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                        cnt_q   <= CNT_ZERO;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign HL_out = HL_SEL ? hi_q : lo_q;

endmodule
